branch_lane: RTL and testbench

//  Parametrised branch issue lane: ID/EX register, branch resolve, registered EX/WB output stage.

---
 rtl/branch_lane.sv | 163 ++++++++++++++++
 tb/tb_branch_lane.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_lane.sv
// Branch issue lane: ID/EX capture, branch resolve, registered EX/WB redirect/link stage,
// squash-window counter and saturating branch/taken performance counters.
module branch_lane #(
   parameter int XLEN          = 32,
   parameter int IMM_W         = 22,
   parameter int SQUASH_CYCLES = 1,
   parameter int INST_BYTES    = 4,
   parameter int ALIGN_BITS    = 2,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             in_valid,
   input  logic             in_is_jmp,
   input  logic             in_is_imm_type,
   input  logic             in_zero_ext,
   input  logic [1:0]       in_op,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [4:0]       in_rd,
   input  logic [IMM_W-1:0] in_imm,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             branch_squash,
   output logic [4:0]       rs1_out,
   output logic [4:0]       rs2_out,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  logic             is_rs1_fwd,
   input  logic             is_rs2_fwd,
   input  logic [XLEN-1:0]  rs1_fwd_data,
   input  logic [XLEN-1:0]  rs2_fwd_data,
   output logic [4:0]       rd_out,
   output logic [XLEN-1:0]  ret_addr,
   output logic             reg_file_wr_en,
   output logic             branch_taken,
   output logic [XLEN-1:0]  new_pc,
   output logic             squash_active,
   input  logic             cnt_clear,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));
   localparam logic [3:0]      SQUASH_LOAD = 4'(SQUASH_CYCLES);

   logic             ex_valid;
   logic             ex_is_jmp;
   logic             ex_is_imm_type;
   logic             ex_zero_ext;
   logic [1:0]       ex_op;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic [IMM_W-1:0] ex_imm;
   logic [XLEN-1:0]  ex_pc;
   logic [3:0]       squash_cnt;

   logic [XLEN-1:0]  op1;
   logic [XLEN-1:0]  op2;
   logic [XLEN-1:0]  imm_ext;
   logic [XLEN-1:0]  target;
   logic [XLEN-1:0]  ret_next;
   logic             cond;
   logic             res_taken;
   logic             res_wr;
   logic             capture_valid;

   assign rs1_out       = ex_rs1;
   assign rs2_out       = ex_rs2;
   assign squash_active = (squash_cnt != 4'd0);

   always_comb begin
      op1  = is_rs1_fwd ? rs1_fwd_data : rs1_data;
      op2  = is_rs2_fwd ? rs2_fwd_data : rs2_data;
      cond = 1'b0;
      case (ex_op)
         2'b00: cond = (op1 == op2);
         2'b01: cond = (op1 != op2);
         2'b10: cond = ($signed(op1) <  $signed(op2));
         2'b11: cond = ($signed(op1) >= $signed(op2));
         default: cond = 1'b0;
      endcase
      imm_ext = ex_zero_ext ? {{(XLEN-IMM_W){1'b0}}, ex_imm}
                            : {{(XLEN-IMM_W){ex_imm[IMM_W-1]}}, ex_imm};
      target    = ((ex_is_imm_type ? op1 : ex_pc) + imm_ext) & ALIGN_MASK;
      ret_next  = ex_pc + XLEN'(INST_BYTES);
      res_taken = ex_valid & (ex_is_jmp | cond);
      res_wr    = ex_valid & ex_is_jmp & (ex_rd != 5'd0);
      // wrong-path slot arriving while a redirect resolves, or inside the window, becomes a NOP
      capture_valid = in_valid & ~branch_squash & (squash_cnt == 4'd0) & ~res_taken;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid       <= 1'b0;
         ex_is_jmp      <= 1'b0;
         ex_is_imm_type <= 1'b0;
         ex_zero_ext    <= 1'b0;
         ex_op          <= 2'b00;
         ex_rs1         <= 5'd0;
         ex_rs2         <= 5'd0;
         ex_rd          <= 5'd0;
         ex_imm         <= '0;
         ex_pc          <= '0;
      end else if (!stall) begin
         ex_valid       <= capture_valid;
         ex_is_jmp      <= in_is_jmp;
         ex_is_imm_type <= in_is_imm_type;
         ex_zero_ext    <= in_zero_ext;
         ex_op          <= in_op;
         ex_rs1         <= in_rs1;
         ex_rs2         <= in_rs2;
         ex_rd          <= in_rd;
         ex_imm         <= in_imm;
         ex_pc          <= in_pc;
      end
   end

   // a stall inserts a bubble so a held branch only pulses once, on release
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_out         <= 5'd0;
         ret_addr       <= '0;
         reg_file_wr_en <= 1'b0;
         branch_taken   <= 1'b0;
         new_pc         <= '0;
      end else if (stall) begin
         reg_file_wr_en <= 1'b0;
         branch_taken   <= 1'b0;
      end else begin
         rd_out         <= ex_rd;
         ret_addr       <= ret_next;
         reg_file_wr_en <= res_wr;
         branch_taken   <= res_taken;
         new_pc         <= target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         squash_cnt <= 4'd0;
      end else if (!stall) begin
         if (res_taken)
            squash_cnt <= SQUASH_LOAD;
         else if (squash_cnt != 4'd0)
            squash_cnt <= squash_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clear) begin
         br_count    <= '0;
         taken_count <= '0;
      end else if (!stall && ex_valid) begin
         if (br_count != '1)
            br_count <= br_count + CNT_W'(1);
         if (res_taken && taken_count != '1)
            taken_count <= taken_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_lane.sv
// Directed bench for branch_lane: expected redirect/link events are queued at issue
// and a negedge monitor pops and compares them whenever the lane presents an output.
module tb_branch_lane;

   logic        clk = 1'b0;
   logic        rst, stall;
   logic        in_valid, in_is_jmp, in_is_imm_type, in_zero_ext;
   logic [1:0]  in_op;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [21:0] in_imm;
   logic [31:0] in_pc;
   logic        branch_squash;
   logic [4:0]  rs1_out, rs2_out;
   logic [31:0] rs1_data, rs2_data;
   logic        is_rs1_fwd, is_rs2_fwd;
   logic [31:0] rs1_fwd_data, rs2_fwd_data;
   logic [4:0]  rd_out;
   logic [31:0] ret_addr;
   logic        reg_file_wr_en, branch_taken;
   logic [31:0] new_pc;
   logic        squash_active;
   logic        cnt_clear;
   logic [3:0]  br_count, taken_count;

   logic [31:0] regs [32];

   typedef struct {
      logic        taken;
      logic [31:0] npc;
      logic        wr;
      logic [4:0]  rd;
      logic [31:0] ret;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      rs1_data = regs[rs1_out];
      rs2_data = regs[rs2_out];
   end

   branch_lane #(.XLEN(32), .IMM_W(22), .SQUASH_CYCLES(2), .INST_BYTES(4),
                 .ALIGN_BITS(2), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .in_valid(in_valid), .in_is_jmp(in_is_jmp), .in_is_imm_type(in_is_imm_type),
      .in_zero_ext(in_zero_ext), .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rd(in_rd), .in_imm(in_imm), .in_pc(in_pc), .branch_squash(branch_squash),
      .rs1_out(rs1_out), .rs2_out(rs2_out), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .is_rs1_fwd(is_rs1_fwd), .is_rs2_fwd(is_rs2_fwd),
      .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
      .rd_out(rd_out), .ret_addr(ret_addr), .reg_file_wr_en(reg_file_wr_en),
      .branch_taken(branch_taken), .new_pc(new_pc), .squash_active(squash_active),
      .cnt_clear(cnt_clear), .br_count(br_count), .taken_count(taken_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push(input logic taken, input logic [31:0] npc, input logic wr,
                       input logic [4:0] rd, input logic [31:0] ret);
      exp_t e;
      e.taken = taken; e.npc = npc; e.wr = wr; e.rd = rd; e.ret = ret;
      exp_q.push_back(e);
   endtask

   task automatic nop();
      in_valid = 1'b0; in_is_jmp = 1'b0; in_is_imm_type = 1'b0; in_zero_ext = 1'b0;
      in_op = 2'b00; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_imm = '0; in_pc = '0;
   endtask

   task automatic issue(input logic jmp, input logic imm_type, input logic zx,
                        input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [21:0] imm, input logic [31:0] pc);
      in_valid = 1'b1; in_is_jmp = jmp; in_is_imm_type = imm_type; in_zero_ext = zx;
      in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm; in_pc = pc;
      @(posedge clk); #1;
      nop();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_counts(input string name, input int br, input int tk);
      check({name, "_br"}, 32'(br_count), 32'(br));
      check({name, "_taken"}, 32'(taken_count), 32'(tk));
   endtask

   always @(negedge clk) begin
      if (branch_taken || reg_file_wr_en) begin
         exp_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: taken=%0b wr=%0b new_pc=0x%0h rd=%0d, none expected",
                     branch_taken, reg_file_wr_en, new_pc, rd_out);
         end else begin
            e = exp_q.pop_front();
            if (branch_taken !== e.taken || reg_file_wr_en !== e.wr ||
                (e.taken && new_pc !== e.npc) ||
                (e.wr && (rd_out !== e.rd || ret_addr !== e.ret))) begin
               errors++;
               $display("FAIL output_event: got taken=%0b pc=0x%0h wr=%0b rd=%0d ret=0x%0h expected taken=%0b pc=0x%0h wr=%0b rd=%0d ret=0x%0h",
                        branch_taken, new_pc, reg_file_wr_en, rd_out, ret_addr,
                        e.taken, e.npc, e.wr, e.rd, e.ret);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      regs[1] = 32'd5; regs[2] = 32'd5; regs[3] = 32'hFFFF_FFFF;
      regs[4] = 32'd1; regs[5] = 32'h203; regs[6] = 32'd2;
      rst = 1'b1; stall = 1'b0; branch_squash = 1'b0; cnt_clear = 1'b0;
      is_rs1_fwd = 1'b0; is_rs2_fwd = 1'b0; rs1_fwd_data = '0; rs2_fwd_data = '0;
      nop();
      idle(2);
      check("rst_taken", 32'(branch_taken), 0);
      check("rst_wr", 32'(reg_file_wr_en), 0);
      check("rst_new_pc", new_pc, 0);
      check("rst_ret", ret_addr, 0);
      check("rst_squash", 32'(squash_active), 0);
      check_counts("rst", 0, 0);
      rst = 1'b0;
      idle(1);

      // BEQ 5==5 -> 0x110
      push(1, 32'h110, 0, 0, 0);
      issue(0, 0, 0, 2'b00, 5'd1, 5'd2, 5'd0, 22'h10, 32'h100);
      idle(4);
      check_counts("beq", 1, 1);

      // taken branch, then JALs: the redirect-cycle slot plus a 2-slot window are squashed
      push(1, 32'h220, 0, 0, 0);
      issue(0, 0, 0, 2'b00, 5'd1, 5'd2, 5'd0, 22'h20, 32'h200);
      issue(1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd7, 22'h40, 32'h300);
      check("win_active", 32'(squash_active), 1);
      issue(1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd8, 22'h40, 32'h304);
      issue(1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd9, 22'h40, 32'h308);
      check("win_closed", 32'(squash_active), 0);
      push(1, 32'h34C, 1, 5'd10, 32'h310);
      issue(1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd10, 22'h40, 32'h30C);
      idle(4);
      check_counts("squash", 3, 3);

      // signed compares, forwarding, sign/zero extension
      is_rs2_fwd = 1'b1; rs2_fwd_data = 32'd0;
      push(1, 32'h408, 0, 0, 0);
      issue(0, 0, 0, 2'b10, 5'd3, 5'd4, 5'd0, 22'h8, 32'h400);
      idle(4);
      is_rs2_fwd = 1'b0;
      push(1, 32'h4F0, 0, 0, 0);
      issue(0, 0, 0, 2'b10, 5'd3, 5'd4, 5'd0, 22'h3FFFF0, 32'h500);
      idle(4);
      push(1, 32'h003F_FFF0, 0, 0, 0);
      issue(0, 0, 1, 2'b01, 5'd1, 5'd6, 5'd0, 22'h3FFFF0, 32'h0);
      idle(4);
      issue(0, 0, 0, 2'b11, 5'd3, 5'd4, 5'd0, 22'h10, 32'h580);
      idle(4);
      check_counts("cmp", 7, 6);

      // JAL rd=0 never writes; rs1-relative target gets its low bits masked
      push(1, 32'h700, 0, 0, 0);
      issue(1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 22'h100, 32'h600);
      idle(4);
      push(1, 32'h200, 1, 5'd3, 32'h704);
      issue(1, 1, 0, 2'b00, 5'd5, 5'd0, 5'd3, 22'h0, 32'h700);
      idle(4);
      check_counts("jal", 9, 8);

      // branch held in ID/EX by a 3-cycle stall pulses once after release
      push(1, 32'h804, 0, 0, 0);
      issue(0, 0, 0, 2'b00, 5'd1, 5'd2, 5'd0, 22'h4, 32'h800);
      stall = 1'b1;
      idle(3);
      check("stall_taken", 32'(branch_taken), 0);
      check_counts("stall_hold", 9, 8);
      stall = 1'b0;
      idle(4);
      check_counts("stall", 10, 9);

      // saturation
      for (int i = 0; i < 20; i++)
         issue(0, 0, 0, 2'b01, 5'd1, 5'd2, 5'd0, 22'h10, 32'hA00);
      idle(2);
      check_counts("sat_br", 15, 9);
      for (int i = 0; i < 7; i++) begin
         push(1, 32'hB00 + 32'(i * 16), 0, 0, 0);
         issue(1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 22'h0, 32'hB00 + 32'(i * 16));
         idle(3);
      end
      check_counts("sat_all", 15, 15);

      // clear on the same cycle as a valid resolve
      issue(0, 0, 0, 2'b01, 5'd1, 5'd2, 5'd0, 22'h10, 32'hC00);
      cnt_clear = 1'b1;
      idle(1);
      cnt_clear = 1'b0;
      check_counts("clear", 0, 0);
      idle(1);
      check_counts("clear_after", 0, 0);

      // reset in the middle of a squash window
      push(1, 32'hD00, 0, 0, 0);
      issue(0, 0, 0, 2'b00, 5'd1, 5'd2, 5'd0, 22'h0, 32'hD00);
      idle(1);
      check("mid_active", 32'(squash_active), 1);
      rst = 1'b1;
      idle(1);
      check("mid_rst_squash", 32'(squash_active), 0);
      check("mid_rst_taken", 32'(branch_taken), 0);
      check("mid_rst_new_pc", new_pc, 0);
      check("mid_rst_ret", ret_addr, 0);
      rst = 1'b0;
      push(1, 32'h910, 0, 0, 0);
      issue(0, 0, 0, 2'b01, 5'd1, 5'd6, 5'd0, 22'h10, 32'h900);
      idle(4);
      check_counts("post_rst", 1, 1);

      check("queue_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
